// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types: shared RV32I pipeline types used by the memory-access stage.
//
// Contents:
//   mem_ctrlwd_t   - memory control word (read/write strobes + funct3 width)
//   ctrl_wd_t      - per-instruction control word carried down the pipeline
//   EX_MEM_stage_t - EX/MEM pipeline register contents
//   MEM_WB_stage_t - MEM/WB pipeline register contents (raw load word + mar)
//   F3_*           - funct3 load/store width encodings
// -----------------------------------------------------------------------------
package rv32i_types;

    // funct3 width encodings shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrlwd_t;

    typedef struct packed {
        logic        load_regfile;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        mem_ctrlwd_t mem_ctrlwd;
    } ctrl_wd_t;

    typedef struct packed {
        ctrl_wd_t    ctrl_wd;
        logic [31:0] alu_out;
        logic        cmp_out;
        logic [31:0] u_imm;
        logic [31:0] rs2_out;
        logic        valid;
    } EX_MEM_stage_t;

    typedef struct packed {
        ctrl_wd_t    ctrl_wd;
        logic [31:0] alu_out;
        logic        cmp_out;
        logic [31:0] u_imm;
        logic [31:0] mar;
        logic [31:0] mdr;
        logic        valid;
    } MEM_WB_stage_t;

endpackage

// File: rtl/mem_access_store_align.sv
// -----------------------------------------------------------------------------
// store_align: places store data on the correct byte lanes of the data-cache
// write bus and generates the matching byte enables.
//
// Ports:
//   funct3 in  3  - store width (sb / sh / sw)
//   off    in  2  - byte offset within the word (alu_out[1:0])
//   rs2    in  32 - store source register value
//   wmask  out 4  - byte enables
//   wdata  out 32 - rs2 shifted to its byte lane
//
// Misaligned halfwords are not trapped; the mask simply shifts off the top.
// -----------------------------------------------------------------------------
module store_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rs2,
    output logic [3:0]  wmask,
    output logic [31:0] wdata
);

    always_comb begin
        wmask = 4'b1111;
        wdata = rs2;
        case (funct3)
            F3_B: begin
                wmask = 4'b0001 << off;
                wdata = rs2 << {off, 3'b000};
            end
            F3_H: begin
                wmask = 4'b0011 << off;
                wdata = rs2 << {off, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access: RV32I memory-access stage. Issues loads/stores to the data cache,
// stalls until the cache responds, and owns the MEM/WB pipeline register.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ex_mem_in           - current MEM instruction (EX_MEM_stage_t)
//   stall_in            - pipeline-wide freeze from other stages
//   dmem_resp/rdata     - cache completion pulse and read word
//   dmem_address        - word-aligned request address
//   dmem_read/write     - request strobes
//   dmem_wmask/wdata    - store byte enables and lane-shifted data
//   mem_stall           - MEM stage not done; upstream registers hold
//   mem_wb_out          - registered MEM/WB contents
//   fsm_state           - current FSM state (debug visibility)
//   perf_loads/stores/stall_cycles - only with MEM_PERF_CNT_EN defined
//
// Handshake: a request is live while dmem_read or dmem_write is high; it
// completes in the first cycle dmem_resp=1 is seen with the request live
// (possibly the issue cycle). dmem_resp with no live request is ignored.
// -----------------------------------------------------------------------------
module mem_access
    import rv32i_types::*;
(
    input  logic          clk,
    input  logic          rst,
    input  EX_MEM_stage_t ex_mem_in,
    input  logic          stall_in,
    input  logic          dmem_resp,
    input  logic [31:0]   dmem_rdata,
    output logic [31:0]   dmem_address,
    output logic          dmem_read,
    output logic          dmem_write,
    output logic [3:0]    dmem_wmask,
    output logic [31:0]   dmem_wdata,
    output logic          mem_stall,
    output MEM_WB_stage_t mem_wb_out,
    output logic [1:0]    fsm_state
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]   perf_loads,
    output logic [31:0]   perf_stores,
    output logic [31:0]   perf_stall_cycles
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   held_q;
    mem_ctrlwd_t   mc;
    logic          mem_op;
    logic          req_active;
    logic          resp_taken;
    logic [3:0]    align_wmask;
    logic [31:0]   mdr_sel;
    MEM_WB_stage_t wb_d;

    assign mc     = ex_mem_in.ctrl_wd.mem_ctrlwd;
    assign mem_op = ex_mem_in.valid & (mc.mem_read | mc.mem_write);

    // DONE means the response is already captured, so no request is reissued.
    assign req_active = ~rst & mem_op & (state_q != ST_DONE);
    assign resp_taken = req_active & dmem_resp;

    store_align u_store_align (
        .funct3 (mc.funct3),
        .off    (ex_mem_in.alu_out[1:0]),
        .rs2    (ex_mem_in.rs2_out),
        .wmask  (align_wmask),
        .wdata  (dmem_wdata)
    );

    assign dmem_address = {ex_mem_in.alu_out[31:2], 2'b00};
    assign dmem_read    = req_active & mc.mem_read;
    assign dmem_write   = req_active & mc.mem_write;
    assign dmem_wmask   = dmem_write ? align_wmask : 4'b0000;
    assign mem_stall    = req_active & ~dmem_resp;
    assign fsm_state    = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (dmem_resp) state_d = stall_in ? ST_DONE : ST_IDLE;
                    else           state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_resp) state_d = stall_in ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!stall_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A same-cycle response wins; otherwise a response parked in DONE is used.
    always_comb begin
        mdr_sel = 32'h0;
        if (resp_taken)             mdr_sel = dmem_rdata;
        else if (state_q == ST_DONE) mdr_sel = held_q;
    end

    always_comb begin
        wb_d         = '0;
        wb_d.ctrl_wd = ex_mem_in.ctrl_wd;
        wb_d.alu_out = ex_mem_in.alu_out;
        wb_d.cmp_out = ex_mem_in.cmp_out;
        wb_d.u_imm   = ex_mem_in.u_imm;
        wb_d.mar     = ex_mem_in.alu_out;
        wb_d.mdr     = mdr_sel;
        wb_d.valid   = ex_mem_in.valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            held_q     <= 32'h0;
            mem_wb_out <= '0;
        end else begin
            state_q <= state_d;
            if (resp_taken) held_q <= dmem_rdata;
            // stall_in freezes everything; an unfinished access inserts a bubble.
            if (!stall_in) mem_wb_out <= mem_stall ? '0 : wb_d;
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads        <= 32'h0;
            perf_stores       <= 32'h0;
            perf_stall_cycles <= 32'h0;
        end else begin
            if (resp_taken & mc.mem_read)  perf_loads  <= perf_loads + 32'd1;
            if (resp_taken & mc.mem_write) perf_stores <= perf_stores + 32'd1;
            if (mem_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access: directed self-checking bench for mem_access. Expected MEM/WB
// entries are queued when an instruction is driven and popped when a valid
// entry appears in MEM/WB; bubbles are checked to be all zero. Perf counter
// checks are compiled in when MEM_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_access;
    import rv32i_types::*;

    logic          clk;
    logic          rst;
    EX_MEM_stage_t ex_mem_in;
    logic          stall_in;
    logic          dmem_resp;
    logic [31:0]   dmem_rdata;
    logic [31:0]   dmem_address;
    logic          dmem_read;
    logic          dmem_write;
    logic [3:0]    dmem_wmask;
    logic [31:0]   dmem_wdata;
    logic          mem_stall;
    MEM_WB_stage_t mem_wb_out;
    logic [1:0]    fsm_state;
`ifdef MEM_PERF_CNT_EN
    logic [31:0]   perf_loads;
    logic [31:0]   perf_stores;
    logic [31:0]   perf_stall_cycles;
`endif

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_in    (ex_mem_in),
        .stall_in     (stall_in),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .mem_stall    (mem_stall),
        .mem_wb_out   (mem_wb_out),
        .fsm_state    (fsm_state)
`ifdef MEM_PERF_CNT_EN
        ,
        .perf_loads        (perf_loads),
        .perf_stores       (perf_stores),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [$bits(MEM_WB_stage_t)-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt = 0;
    logic pend_load = 1'b0;
    logic pend_bubble = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input MEM_WB_stage_t obs, input MEM_WB_stage_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic EX_MEM_stage_t mk(input logic ld, input logic wr, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] rs2);
        EX_MEM_stage_t e;
        e = '0;
        e.valid                       = 1'b1;
        e.ctrl_wd.load_regfile        = ~wr;
        e.ctrl_wd.rd                  = 5'd7;
        e.ctrl_wd.wb_sel              = ld ? 2'd1 : 2'd0;
        e.ctrl_wd.mem_ctrlwd.mem_read = ld;
        e.ctrl_wd.mem_ctrlwd.mem_write = wr;
        e.ctrl_wd.mem_ctrlwd.funct3   = f3;
        e.alu_out                     = addr;
        e.cmp_out                     = 1'b1;
        e.u_imm                       = 32'h0000_1000;
        e.rs2_out                     = rs2;
        return e;
    endfunction

    function automatic MEM_WB_stage_t exp_wb(input EX_MEM_stage_t e, input logic [31:0] mdr);
        MEM_WB_stage_t w;
        w         = '0;
        w.ctrl_wd = e.ctrl_wd;
        w.alu_out = e.alu_out;
        w.cmp_out = e.cmp_out;
        w.u_imm   = e.u_imm;
        w.mar     = e.alu_out;
        w.mdr     = mdr;
        w.valid   = e.valid;
        return w;
    endfunction

    // Inputs change only just after posedge, so values at negedge are the ones
    // the next posedge sees. Check the result of the previous edge, then record
    // what the coming edge should do to MEM/WB.
    always @(negedge clk) begin
        MEM_WB_stage_t exp_v;
        MEM_WB_stage_t obs_v;
        if (pend_load) begin
            if (pend_bubble) begin
                chk_wb("wb_bubble", mem_wb_out, '0);
            end else if (mem_wb_out.valid) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL wb_unexpected: observed %h expected none", mem_wb_out);
                end
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    obs_v = mem_wb_out;
                    if (!exp_v.ctrl_wd.mem_ctrlwd.mem_read) begin
                        exp_v.mdr = '0;
                        obs_v.mdr = '0;
                    end
                    chk_wb("wb_entry", obs_v, exp_v);
                end
            end
        end
        if (mem_stall === 1'b1) stall_cnt++;
        pend_load   = !rst && !stall_in;
        pend_bubble = mem_stall;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Store completing with a same-cycle response.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [31:0] e_addr,
                            input logic [3:0] e_mask, input logic [31:0] e_wdata);
        EX_MEM_stage_t e;
        e = mk(1'b0, 1'b1, f3, addr, rs2);
        ex_mem_in = e;
        exp_q.push_back(exp_wb(e, 32'h0));
        dmem_resp = 1'b1;
        settle();
        chk({tag, "_write"}, {31'h0, dmem_write}, 32'h1);
        chk({tag, "_read"},  {31'h0, dmem_read},  32'h0);
        chk({tag, "_addr"},  dmem_address, e_addr);
        chk({tag, "_wmask"}, {28'h0, dmem_wmask}, {28'h0, e_mask});
        chk({tag, "_wdata"}, dmem_wdata, e_wdata);
        chk({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
        tick();
        dmem_resp = 1'b0;
        ex_mem_in = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        EX_MEM_stage_t e;
        int base;
        logic [31:0] r;

        rst = 1'b1; stall_in = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0; ex_mem_in = '0;
        repeat (2) tick();
        chk_wb("rst_wb", mem_wb_out, '0);
        chk("rst_read",  {31'h0, dmem_read},  32'h0);
        chk("rst_write", {31'h0, dmem_write}, 32'h0);
        chk("rst_wmask", {28'h0, dmem_wmask}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall},  32'h0);
        chk("rst_state", {30'h0, fsm_state},  32'h0);
        rst = 1'b0;
        tick();

        // Non-memory instruction: one cycle, no request.
        e = mk(1'b0, 1'b0, F3_W, 32'h0000_1234, 32'h0);
        ex_mem_in = e;
        exp_q.push_back(exp_wb(e, 32'h0));
        base = stall_cnt;
        settle();
        chk("add_read",  {31'h0, dmem_read},  32'h0);
        chk("add_write", {31'h0, dmem_write}, 32'h0);
        chk("add_stall", {31'h0, mem_stall},  32'h0);
        tick();
        ex_mem_in = '0;
        chk("add_alu", mem_wb_out.alu_out, 32'h0000_1234);
        chk("add_stall_cnt", stall_cnt - base, 32'd0);

        // lw with response three cycles after the request.
        e = mk(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
        ex_mem_in = e;
        exp_q.push_back(exp_wb(e, 32'hDEAD_BEEF));
        base = stall_cnt;
        settle();
        chk("lw_read",  {31'h0, dmem_read}, 32'h1);
        chk("lw_addr",  dmem_address, 32'h0000_0100);
        chk("lw_wmask", {28'h0, dmem_wmask}, 32'h0);
        chk("lw_stall", {31'h0, mem_stall}, 32'h1);
        tick();
        chk("lw_state_wait", {30'h0, fsm_state}, 32'd1);
        tick();
        tick();
        chk("lw_read_held", {31'h0, dmem_read}, 32'h1);
        dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("lw_resp_stall", {31'h0, mem_stall}, 32'h0);
        chk("lw_addr_held", dmem_address, 32'h0000_0100);
        tick();
        dmem_resp = 1'b0; dmem_rdata = 32'h0; ex_mem_in = '0;
        chk("lw_stall_cnt", stall_cnt - base, 32'd3);
        chk("lw_mdr", mem_wb_out.mdr, 32'hDEAD_BEEF);
        chk("lw_mar", mem_wb_out.mar, 32'h0000_0100);
        chk("lw_state_idle", {30'h0, fsm_state}, 32'd0);

        // Store lane alignment.
        do_store("sb3", F3_B, 32'h0000_0203, 32'h0000_00AB, 32'h0000_0200, 4'b1000, 32'hAB00_0000);
        do_store("sh2", F3_H, 32'h0000_0202, 32'h0000_1234, 32'h0000_0200, 4'b1100, 32'h1234_0000);
        do_store("sw0", F3_W, 32'h0000_0300, 32'hCAFE_F00D, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D);
        r = $urandom_range(32'hFFFF, 0);
        do_store("sb1", F3_B, 32'h0000_0201, r, 32'h0000_0200, 4'b0010, r << 8);
        r = $urandom_range(32'hFFFF, 0);
        do_store("sh3", F3_H, 32'h0000_0203, r, 32'h0000_0200, 4'b1000, r << 24);

        // lw whose response lands while the pipeline is frozen.
        e = mk(1'b1, 1'b0, F3_W, 32'h0000_0040, 32'h0);
        ex_mem_in = e;
        exp_q.push_back(exp_wb(e, 32'h0000_0055));
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'h0000_0055; stall_in = 1'b1;
        tick();
        dmem_resp = 1'b0; dmem_rdata = 32'h0000_0099;
        settle();
        chk("frz_state_done", {30'h0, fsm_state}, 32'd2);
        chk("frz_no_reissue", {31'h0, dmem_read}, 32'h0);
        chk("frz_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        chk("frz_still_done", {30'h0, fsm_state}, 32'd2);
        stall_in = 1'b0;
        tick();
        ex_mem_in = '0;
        chk("frz_mdr", mem_wb_out.mdr, 32'h0000_0055);
        chk("frz_state_idle", {30'h0, fsm_state}, 32'd0);

        // Stray response with no request is ignored.
        e = mk(1'b0, 1'b0, F3_W, 32'h0000_55AA, 32'h0);
        ex_mem_in = e;
        exp_q.push_back(exp_wb(e, 32'h0));
        dmem_resp = 1'b1; dmem_rdata = 32'h0000_0777;
        settle();
        chk("stray_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        dmem_resp = 1'b0; ex_mem_in = '0;
        chk("stray_state", {30'h0, fsm_state}, 32'd0);

        // Reset while waiting abandons the access.
        ex_mem_in = mk(1'b1, 1'b0, F3_W, 32'h0000_0080, 32'h0);
        tick();
        chk("rstw_state_wait", {30'h0, fsm_state}, 32'd1);
        rst = 1'b1; ex_mem_in = '0;
        tick();
        chk("rstw_read",  {31'h0, dmem_read}, 32'h0);
        chk("rstw_state", {30'h0, fsm_state}, 32'd0);
        chk_wb("rstw_wb", mem_wb_out, '0);
        rst = 1'b0;
        tick();

`ifdef MEM_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r = $urandom();
            e = mk(1'b1, 1'b0, F3_W, 32'h0000_0400 + 32'(4 * i), 32'h0);
            ex_mem_in = e;
            exp_q.push_back(exp_wb(e, r));
            tick();
            tick();
            dmem_resp = 1'b1; dmem_rdata = r;
            tick();
            dmem_resp = 1'b0; ex_mem_in = '0;
        end
        do_store("psw", F3_W, 32'h0000_0500, 32'h1111_2222, 32'h0000_0500, 4'b1111, 32'h1111_2222);
        chk("perf_loads", perf_loads, 32'd2);
        chk("perf_stores", perf_stores, 32'd1);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd4);
`endif

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RV32I pipeline, between the EX/MEM pipeline register and the write-back stage. It issues loads and stores to the data cache over a request/response handshake and stalls the pipeline until the cache responds. It owns the MEM/WB pipeline register and fills it with the raw load word plus byte address, for byte/halfword extraction in write-back.

## Interface
- No parameters; widths are fixed by `rv32i_types`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_mem_in` in `EX_MEM_stage_t`: the current MEM instruction (`ctrl_wd`, `alu_out`, `cmp_out`, `u_imm`, `rs2_out`, `valid`).
- `stall_in` in 1: pipeline-wide freeze from other stages (e.g. I-cache miss).
- `dmem_resp` in 1: one-cycle cache completion pulse.
- `dmem_rdata` in 32: read word, valid when `dmem_resp`=1.
- `dmem_address` out 32: `{alu_out[31:2],2'b00}`.
- `dmem_read` out 1, `dmem_write` out 1: request strobes.
- `dmem_wmask` out 4: byte enables for stores.
- `dmem_wdata` out 32: store data shifted to byte lane.
- `mem_stall` out 1: MEM stage not done; upstream registers hold.
- `mem_wb_out` out `MEM_WB_stage_t`: registered MEM/WB contents.

## Operation
- Memory op = `valid & (mem_read | mem_write)` from `ex_mem_in.ctrl_wd.mem_ctrlwd`. Non-memory instructions pass through in one cycle with no request.
- FSM states:
  - IDLE: drive the request when a memory op is present. `dmem_resp`=1 in the same cycle completes it. A resp with `stall_in`=1 goes to DONE. No resp goes to WAIT.
  - WAIT: hold request and address constant. On `dmem_resp`, go to IDLE, or to DONE if `stall_in`=1.
  - DONE: no request; `dmem_rdata` is held in an internal register. Go to IDLE when `stall_in`=0.
- `mem_stall` = memory op & (state≠DONE) & ~`dmem_resp`. It is combinational.
- Store lanes, with `off`=`alu_out[1:0]`:
  - sb: `wmask`=`4'b0001<<off`, `wdata`=`rs2<<(8*off)`.
  - sh: `wmask`=`4'b0011<<off`, `wdata`=`rs2<<(8*off)`.
  - sw: `wmask`=`4'b1111`, `wdata`=`rs2`.
- Loads drive `wmask`=0. Misaligned accesses are not detected; lanes are computed as above.
- MEM/WB load rule:
  - `stall_in`=1: hold.
  - Else `mem_stall`=1: load a bubble (all zero; `valid`=0, `load_regfile`=0).
  - Else: load `ctrl_wd`, `alu_out`, `cmp_out`, `u_imm`, `mar`=`alu_out`, and `mdr`. `mdr` comes from `dmem_rdata` on a same-cycle resp, else from the held register in DONE.
- Every instruction reaches MEM/WB exactly once; no request is reissued after its response.

## Timing
- Reset values:
  - `mem_wb_out` all zero.
  - FSM in IDLE, held data 0.
  - `dmem_read`, `dmem_write`, `dmem_wmask` = 0.
  - `mem_stall`=0.
- A reset mid-request abandons the transaction; the cache must tolerate strobe drop.
- Latency:
  - Non-memory instruction: 1 cycle to MEM/WB.
  - Memory instruction with response N cycles after request (N≥0): N+1 cycles.
- `dmem_resp` outside a request is ignored.
- Stall priority: `rst` > `stall_in` > `mem_stall`.

## Configuration
- `MEM_PERF_CNT_EN` defined:
  - Adds 32-bit output ports `perf_loads`, `perf_stores`, `perf_stall_cycles`. Each resets to 0 and wraps at 2^32.
  - `perf_loads` / `perf_stores` increment once per completed load/store.
  - `perf_stall_cycles` increments on each cycle with `mem_stall`=1.
- Undefined: ports and counters are absent; functional behaviour is identical.

## Structure
- `rv32i_types` owns `EX_MEM_stage_t`, `MEM_WB_stage_t`, `mem_ctrlwd`, and the funct3 load/store width encodings.
- The FSM state enum stays local.
- Sub-module `store_align`: combinational lane shift and `wmask` generation from funct3 and `off`.

## Test plan
- `add` with `alu_out`=0x1234, no memory op -> no request; next cycle `mem_wb_out.alu_out`=0x1234, `mem_stall` never 1.
- lw at 0x100, resp after 3 cycles with 0xDEADBEEF -> `mem_stall` high 3 cycles, bubbles enter MEM/WB, then `mdr`=0xDEADBEEF and `mar`=0x100.
- sb `rs2`=0xAB at 0x203 -> `address`=0x200, `wmask`=1000, `wdata`=0xAB000000. sh at 0x202 -> `wmask`=1100.
- lw with `stall_in`=1 when resp arrives (rdata 0x55) -> FSM enters DONE, no reissue; when `stall_in` falls, `mdr`=0x55 loads next cycle.
- `rst` asserted while in WAIT -> next cycle strobes 0, FSM IDLE, `mem_wb_out` all zero.
- With `MEM_PERF_CNT_EN`: 2 loads (2-cycle resp) + 1 store (0-cycle resp) -> `perf_loads`=2, `perf_stores`=1, `perf_stall_cycles`=4.
